// File: rtl/axil_axis_bridge.sv
// axil_axis_bridge: AXI-lite slave that queues words written to TXDATA in a
// FIFO and drains them as AXI-stream beats on the m_ port. STATUS reports
// occupancy and a sticky overflow flag; CTRL clears overflow and flushes.
// Optional feature macro: AXIS_TLAST_EN (adds m_last and the TXLAST address).
//
// Handshake rule for every channel (AW, W, B, AR, R, m_): a transfer happens on
// a rising edge where valid and ready are both high; a source never drops
// valid before the transfer, except m_valid on a CTRL flush.
`default_nettype none

module axil_axis_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [31:0]           awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  bvalid,
  output logic                  bresp,
  input  logic                  bready,
  input  logic [31:0]           araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
`ifdef AXIS_TLAST_EN
  output logic                  m_last,
`endif
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef AXIS_TLAST_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_TXLAST = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  // Write-channel capture registers
  logic                  aw_have, w_have;
  logic [1:0]            aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  bresp_q;

  // FIFO state
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  // Read path
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_value;

  // Decoded commit controls
  logic                  aw_fire, w_fire, ar_fire;
  logic                  commit;
  logic [1:0]            cmt_addr;
  logic [DATA_WIDTH-1:0] cmt_data;
  logic                  push_req, push_last, push_ok, pop;
  logic                  flush, ovf_clr, unmapped, wr_err;
  logic                  full, empty;
  logic [EW-1:0]         entry;

  // A commit may use a beat captured earlier or one handshaking this cycle,
  // so AW and W arriving together commit without an extra wait cycle.
  assign aw_fire  = awvalid & awready;
  assign w_fire   = wvalid & wready;
  assign ar_fire  = arvalid & arready;
  assign commit   = (w_state == W_IDLE) & (aw_have | aw_fire) & (w_have | w_fire);
  assign cmt_addr = aw_have ? aw_addr_q : awaddr[3:2];
  assign cmt_data = w_have ? w_data_q : wdata;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Decode the committed write into FIFO / CTRL actions and the error response
  always_comb begin
    push_req  = 1'b0;
    push_last = 1'b0;
    unmapped  = 1'b0;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    if (commit) begin
      case (cmt_addr)
        A_TXDATA: push_req = 1'b1;
        A_CTRL: begin
          ovf_clr = cmt_data[0];
          flush   = cmt_data[1];
        end
        A_TXLAST: begin
`ifdef AXIS_TLAST_EN
          push_req  = 1'b1;
          push_last = 1'b1;
`else
          unmapped  = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    // A flush cancels any beat handshaking in the same cycle.
    pop     = m_valid & m_ready & ~flush;
    push_ok = push_req & (~full | pop);
    wr_err  = unmapped | (push_req & ~push_ok);
  end

`ifdef AXIS_TLAST_EN
  assign entry = {push_last, cmt_data};
`else
  assign entry = cmt_data;
`endif

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write FSM next state and channel handshake outputs
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ~aw_have;
        wready  = ~w_have;
        if (commit) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Hold AW/W beats that arrive before their partner; latch response code
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bresp_q   <= 1'b0;
    end else if (commit) begin
      aw_have <= 1'b0;
      w_have  <= 1'b0;
      bresp_q <= wr_err;
    end else begin
      if (aw_fire) begin
        aw_have   <= 1'b1;
        aw_addr_q <= awaddr[3:2];
      end
      if (w_fire) begin
        w_have   <= 1'b1;
        w_data_q <= wdata;
      end
    end
  end

  assign bresp = bresp_q;

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop);
      end
      if (ovf_clr)
        overflow <= 1'b0;
      else if (push_req & ~push_ok)
        overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful while counted
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  assign m_valid = ~empty;
  assign m_data  = mem[rd_ptr][DATA_WIDTH-1:0];
`ifdef AXIS_TLAST_EN
  assign m_last  = m_valid & mem[rd_ptr][DATA_WIDTH];
`endif

  // STATUS word and read-address mux
  always_comb begin
    status_word           = '0;
    status_word[CW-1:0]   = count;
    status_word[16]       = empty;
    status_word[17]       = full;
    status_word[18]       = overflow;
    rd_value              = '0;
    if (araddr[3:2] == A_STATUS) rd_value = status_word;
  end

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read FSM next state and channel handshake outputs
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Sample the addressed register at AR capture
  always_ff @(posedge aclk) begin
    if (areset)       rdata_q <= '0;
    else if (ar_fire) rdata_q <= rd_value;
  end

  assign rdata = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{awaddr[31:4], awaddr[1:0], araddr[31:4], araddr[1:0]};

endmodule

`default_nettype wire
